fb_scanout: RTL and testbench

- Parametrised framebuffer scanout engine between the LCD timing generator (haddr/vaddr/DE/syncs) and the frame-buffer RAM read port.
- Generates scaled read addresses by incremental row-pivot arithmetic, with no multiplier.
- Supports double-buffered pages swapped only at frame boundaries, and three packed pixel formats plus a solid-fill mode.
- Returns 24-bit RGB and delayed DE/HSYNC/VSYNC, all aligned to each other.

---
 rtl/fb_pkg.sv | 44 ++++
 rtl/fb_pix_expand.sv | 52 +++++
 rtl/fb_scanout.sv | 165 ++++++++++++++++
 tb/tb_fb_scanout.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// ============================================================================
// Module   : fb_pkg
// Purpose  : Shared types and colour-expansion helpers for the scanout engine.
// Revision : 1.0
// ============================================================================
`default_nettype none

package fb_pkg;

    typedef enum logic [1:0] {
        FB_RGB565 = 2'd0,
        FB_GRAY8  = 2'd1,
        FB_RGB332 = 2'd2,
        FB_SOLID  = 2'd3
    } fb_mode_t;

    typedef logic [23:0] rgb24_t;

    // Control word carried alongside the RAM access so everything lands together.
    typedef struct packed {
        logic     de;
        logic     hs;
        logic     vs;
        fb_mode_t mode;
        logic     bsel;
    } fb_ctl_t;

    function automatic rgb24_t expand_565(input logic [15:0] w);
        return {w[15:11], w[15:13], w[10:5], w[10:9], w[4:0], w[4:2]};
    endfunction

    function automatic rgb24_t expand_gray(input logic [7:0] y);
        return {y, y, y};
    endfunction

    function automatic rgb24_t expand_332(input logic [7:0] b);
        return {b[7:5], b[7:5], b[7:6],
                b[4:2], b[4:2], b[4:3],
                b[1:0], b[1:0], b[1:0], b[1:0]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/fb_pix_expand.sv
// ============================================================================
// Module   : fb_pix_expand
// Purpose  : Registered colour expansion of one RAM word into 24-bit RGB.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fb_pix_expand
    import fb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  fb_mode_t    i_mode,
    input  logic        i_byte_sel,
    input  logic [15:0] i_rdata,
    input  rgb24_t      i_fill,
    input  logic        i_de,
    output rgb24_t      o_color
);

    logic [7:0] w_byte;
    rgb24_t     w_color;
    rgb24_t     r_color;

    assign w_byte = i_byte_sel ? i_rdata[15:8] : i_rdata[7:0];

    always_comb begin
        w_color = '0;
        if (i_de) begin
            case (i_mode)
                FB_RGB565: w_color = expand_565(i_rdata);
                FB_GRAY8:  w_color = expand_gray(w_byte);
                FB_RGB332: w_color = expand_332(w_byte);
                FB_SOLID:  w_color = i_fill;
                default:   w_color = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_color <= '0;
        end else begin
            r_color <= w_color;
        end
    end

    assign o_color = r_color;

endmodule

`default_nettype wire

// File: rtl/fb_scanout.sv
// ============================================================================
// Module   : fb_scanout
// Purpose  : Framebuffer scanout: scaled address generation, page flipping,
//            RAM read pipeline and sync delay matching.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fb_scanout
    import fb_pkg::*;
#(
    parameter int H_ACTIVE   = 800,
    parameter int V_ACTIVE   = 480,
    parameter int SCALE_LOG2 = 1,
    parameter int ADDR_W     = 18,
    parameter int DATA_W     = 16,
    parameter int RD_LAT     = 2,
    parameter int PAGE_WORDS = 96000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        i_haddr,
    input  logic [8:0]        i_vaddr,
    input  logic              i_de,
    input  logic              i_hsync,
    input  logic              i_vsync,
    input  logic [1:0]        i_mode,
    input  logic [23:0]       i_fill,
    input  logic              i_swap_req,
    output logic              o_swap_ack,
    output logic              o_front_page,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_rd_en,
    input  logic [DATA_W-1:0] i_rdata,
    output logic [23:0]       o_color,
    output logic              o_de,
    output logic              o_hsync,
    output logic              o_vsync
);

    localparam logic [ADDR_W:0]   c_piv_step = (ADDR_W+1)'(H_ACTIVE >> SCALE_LOG2);
    localparam logic [8:0]        c_vmask    = 9'((1 << SCALE_LOG2) - 1);
    localparam logic [9:0]        c_h_last   = 10'(H_ACTIVE - 1);
    localparam logic [9:0]        c_v_active = 10'(V_ACTIVE);
    localparam logic [ADDR_W-1:0] c_page1    = ADDR_W'(PAGE_WORDS);

    logic              r_vs_prev;
    logic              w_frame_edge;
    fb_mode_t          r_mode;
    logic              r_front;
    logic              r_pend;
    logic              r_ack;
    logic [ADDR_W:0]   r_piv;
    logic              r_piv_run;
    logic [ADDR_W-1:0] r_addr;
    logic              r_rd_en;
    logic              r_de_o;
    logic              r_hs_o;
    logic              r_vs_o;
    fb_ctl_t           r_dly [0:RD_LAT];

    logic              w_active_line;
    logic              w_line_end;
    logic              w_read;
    logic [ADDR_W:0]   w_idx;
    logic [ADDR_W-1:0] w_word;
    logic [ADDR_W-1:0] w_base;
    fb_ctl_t           w_ctl;

    assign w_frame_edge  = i_vsync & ~r_vs_prev;
    assign w_active_line = {1'b0, i_vaddr} < c_v_active;
    assign w_read        = i_de & (r_mode != FB_SOLID) & w_active_line;
    // Pivot only accumulates once a known line origin (vaddr 0 or vsync) has been seen.
    assign w_line_end    = i_de & (i_haddr == c_h_last) & ((i_vaddr & c_vmask) == c_vmask)
                         & w_active_line & r_piv_run;

    assign w_idx  = r_piv + (ADDR_W+1)'(i_haddr >> SCALE_LOG2);
    assign w_word = (r_mode == FB_RGB565) ? w_idx[ADDR_W-1:0] : w_idx[ADDR_W:1];
    assign w_base = r_front ? c_page1 : '0;

    assign w_ctl = '{de: i_de, hs: i_hsync, vs: i_vsync, mode: r_mode, bsel: w_idx[0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vs_prev <= 1'b0;
            r_mode    <= FB_RGB565;
            r_front   <= 1'b0;
            r_pend    <= 1'b0;
            r_ack     <= 1'b0;
            r_piv     <= '0;
            r_piv_run <= 1'b0;
            r_addr    <= '0;
            r_rd_en   <= 1'b0;
        end else begin
            r_vs_prev <= i_vsync;
            r_ack     <= 1'b0;
            r_rd_en   <= w_read;
            if (w_read) begin
                r_addr <= w_base + w_word;
            end
            if (w_frame_edge) begin
                r_mode    <= fb_mode_t'(i_mode);
                r_piv     <= '0;
                r_piv_run <= 1'b1;
                if (r_pend || i_swap_req) begin
                    r_front <= ~r_front;
                    r_pend  <= 1'b0;
                    r_ack   <= 1'b1;
                end
            end else begin
                if (i_swap_req) begin
                    r_pend <= 1'b1;
                end
                if (i_de && (i_vaddr == 9'd0)) begin
                    r_piv_run <= 1'b1;
                end
                if (w_line_end) begin
                    r_piv <= r_piv + c_piv_step;
                end
            end
        end
    end

    // Stage A register plus RD_LAT stages so control meets the returning RAM word.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= RD_LAT; i++) begin
                r_dly[i] <= '0;
            end
            r_de_o <= 1'b0;
            r_hs_o <= 1'b0;
            r_vs_o <= 1'b0;
        end else begin
            r_dly[0] <= w_ctl;
            for (int i = 1; i <= RD_LAT; i++) begin
                r_dly[i] <= r_dly[i-1];
            end
            r_de_o <= r_dly[RD_LAT].de;
            r_hs_o <= r_dly[RD_LAT].hs;
            r_vs_o <= r_dly[RD_LAT].vs;
        end
    end

    fb_pix_expand u_expand (
        .clk        (clk),
        .rst        (rst),
        .i_mode     (r_dly[RD_LAT].mode),
        .i_byte_sel (r_dly[RD_LAT].bsel),
        .i_rdata    (i_rdata),
        .i_fill     (i_fill),
        .i_de       (r_dly[RD_LAT].de),
        .o_color    (o_color)
    );

    assign o_swap_ack   = r_ack;
    assign o_front_page = r_front;
    assign o_addr       = r_addr;
    assign o_rd_en      = r_rd_en;
    assign o_de         = r_de_o;
    assign o_hsync      = r_hs_o;
    assign o_vsync      = r_vs_o;

endmodule

`default_nettype wire

// File: tb/tb_fb_scanout.sv
// ============================================================================
// Module   : tb_fb_scanout
// Purpose  : Scoreboard bench for fb_scanout with a latency-modelled RAM.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fb_scanout;

    localparam int RD_LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  i_haddr;
    logic [8:0]  i_vaddr;
    logic        i_de, i_hsync, i_vsync, i_swap_req;
    logic [1:0]  i_mode;
    logic [23:0] i_fill;
    logic        o_swap_ack, o_front_page, o_rd_en;
    logic [17:0] o_addr;
    logic [15:0] i_rdata;
    logic [23:0] o_color;
    logic        o_de, o_hsync, o_vsync;

    fb_scanout #(.RD_LAT(RD_LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_haddr      (i_haddr),
        .i_vaddr      (i_vaddr),
        .i_de         (i_de),
        .i_hsync      (i_hsync),
        .i_vsync      (i_vsync),
        .i_mode       (i_mode),
        .i_fill       (i_fill),
        .i_swap_req   (i_swap_req),
        .o_swap_ack   (o_swap_ack),
        .o_front_page (o_front_page),
        .o_addr       (o_addr),
        .o_rd_en      (o_rd_en),
        .i_rdata      (i_rdata),
        .o_color      (o_color),
        .o_de         (o_de),
        .o_hsync      (o_hsync),
        .o_vsync      (o_vsync)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM: word index folded to 10 bits; address pipeline gives RD_LAT cycles.
    logic [15:0] mem [0:1023];
    logic [17:0] rp  [0:RD_LAT-1];
    always @(posedge clk) begin
        rp[0] <= o_addr;
        for (int k = 1; k < RD_LAT; k++) rp[k] <= rp[k-1];
    end
    assign i_rdata = mem[rp[RD_LAT-1][9:0]];

    typedef struct { int addr; int cyc; } aexp_t;
    typedef struct { logic [23:0] color; int cyc; bit chk; bit hs; } cexp_t;
    aexp_t aq[$];
    cexp_t cq[$];
    int    vq[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input int h, input int v, input bit rd, input int addr,
                       input logic [23:0] col, input bit chk = 1'b1, input bit hs = 1'b0);
        i_de = 1'b1; i_haddr = 10'(h); i_vaddr = 9'(v); i_hsync = hs;
        if (rd) aq.push_back('{addr: addr, cyc: cyc + 1});
        cq.push_back('{color: col, cyc: cyc + 4, chk: chk, hs: hs});
        tick;
        i_de = 1'b0; i_hsync = 1'b0;
    endtask

    task automatic frame(input int mode, input bit swap, input bit exp_ack, input bit exp_page);
        i_vsync = 1'b1; i_mode = 2'(mode); i_swap_req = swap;
        vq.push_back(cyc + 4);
        tick;
        check("swap_ack_at_edge", 32'(o_swap_ack), 32'(exp_ack));
        check("front_page_at_edge", 32'(o_front_page), 32'(exp_page));
        i_vsync = 1'b0; i_swap_req = 1'b0;
        tick;
        check("swap_ack_one_cycle", 32'(o_swap_ack), 32'd0);
    endtask

    // Monitor: pops expectations whenever the DUT presents a read or a pixel.
    logic prev_de = 1'b0, prev_vs = 1'b0;
    always @(negedge clk) begin
        if (o_rd_en) begin
            if (aq.size() == 0) check("unexpected_read", 32'(o_addr), 32'hFFFFFFFF);
            else begin
                aexp_t a;
                a = aq.pop_front();
                check("rd_addr", 32'(o_addr), 32'(a.addr));
                check("rd_cycle", 32'(cyc), 32'(a.cyc));
            end
        end
        if (o_de) begin
            if (cq.size() == 0) check("unexpected_de", 32'(o_color), 32'hFFFFFFFF);
            else begin
                cexp_t c;
                c = cq.pop_front();
                if (c.chk) check("color", 32'(o_color), 32'(c.color));
                check("de_cycle", 32'(cyc), 32'(c.cyc));
                check("hsync_align", 32'(o_hsync), 32'(c.hs));
            end
        end
        if (prev_de && !o_de) check("color_zero_no_de", 32'(o_color), 32'd0);
        if (o_vsync && !prev_vs) begin
            if (vq.size() == 0) check("unexpected_vsync", 32'(cyc), 32'hFFFFFFFF);
            else check("vsync_cycle", 32'(cyc), 32'(vq.pop_front()));
        end
        prev_de <= o_de;
        prev_vs <= o_vsync;
    end

    initial begin
        for (int k = 0; k < 1024; k++) mem[k] = 16'h0000;
        mem[0]   = 16'h001F;
        mem[199] = 16'h5500;
        mem[201] = 16'h3C80;
        mem[202] = 16'h00E0;
        mem[402] = 16'hF800;
        mem[403] = 16'h07E0;
        mem[404] = 16'h001F;
        mem[405] = 16'h0000;
        rst = 1'b1; i_haddr = '0; i_vaddr = '0; i_de = 1'b0; i_hsync = 1'b0;
        i_vsync = 1'b0; i_mode = 2'd0; i_fill = 24'h0; i_swap_req = 1'b0;
        repeat (3) tick;
        check("reset_outputs", {o_addr, o_rd_en, o_de, o_hsync, o_vsync, o_swap_ack, o_front_page},
              32'd0);
        check("reset_color", 32'(o_color), 32'd0);
        rst = 1'b0;
        tick;

        // RGB565 basics and pivot across line 1
        frame(0, 1'b0, 1'b0, 1'b0);
        pix(799, 1, 1'b1, 399, 24'h000000);
        pix(5, 3, 1'b1, 402, 24'hFF0000);
        pix(7, 3, 1'b1, 403, 24'h00FF00, 1'b1, 1'b1);
        pix(9, 3, 1'b1, 404, 24'h0000FF);
        pix(11, 3, 1'b1, 405, 24'h000000);
        repeat (6) tick;

        // Mid-frame swap request waits for the vsync edge
        i_swap_req = 1'b1;
        tick;
        i_swap_req = 1'b0;
        check("no_flip_midframe", {o_front_page, o_swap_ack}, 32'd0);
        repeat (3) tick;
        check("still_page0", 32'(o_front_page), 32'd0);
        frame(0, 1'b0, 1'b1, 1'b1);
        pix(799, 1, 1'b1, 96399, 24'h000000);
        pix(5, 3, 1'b1, 96402, 24'h000000);
        frame(0, 1'b1, 1'b1, 1'b0);

        // GRAY8, with a mid-frame mode change that must be ignored
        frame(1, 1'b0, 1'b0, 1'b0);
        pix(799, 1, 1'b1, 199, 24'h555555);
        pix(5, 3, 1'b1, 201, 24'h808080);
        pix(7, 3, 1'b1, 201, 24'h3C3C3C);
        i_mode = 2'd3;
        tick;
        pix(9, 3, 1'b1, 202, 24'hE0E0E0);

        // RGB332
        frame(2, 1'b0, 1'b0, 1'b0);
        pix(799, 1, 1'b1, 199, 24'h49B655);
        pix(5, 3, 1'b1, 201, 24'h920000);
        pix(7, 3, 1'b1, 201, 24'h24FF00);

        // SOLID: no reads at all
        i_fill = 24'h123456;
        frame(3, 1'b0, 1'b0, 1'b0);
        pix(799, 1, 1'b0, 0, 24'h123456);
        pix(5, 3, 1'b0, 0, 24'h123456);

        // Pivot steps only on odd lines; line 480 issues no read
        frame(0, 1'b1, 1'b1, 1'b1);
        pix(799, 1, 1'b1, 96399, 24'h000000);
        pix(799, 2, 1'b1, 96799, 24'h000000);
        pix(799, 3, 1'b1, 96799, 24'h000000);
        pix(0, 4, 1'b1, 96800, 24'h000000);
        pix(0, 480, 1'b0, 0, 24'h000000, 1'b0);
        repeat (6) tick;

        // Reset mid-line flushes the in-flight pixel
        i_de = 1'b1; i_haddr = 10'd2; i_vaddr = 9'd5;
        aq.push_back('{addr: 96801, cyc: cyc + 1});
        tick;
        i_de = 1'b0;
        rst = 1'b1;
        tick;
        check("rst_midline_outputs", {o_addr, o_rd_en, o_de, o_hsync, o_vsync, o_swap_ack, o_front_page},
              32'd0);
        check("rst_midline_color", 32'(o_color), 32'd0);
        tick;
        rst = 1'b0;
        repeat (6) tick;
        frame(0, 1'b0, 1'b0, 1'b0);
        pix(0, 0, 1'b1, 0, 24'h0000FF);

        for (int k = 0; k < 50 && (aq.size() + cq.size() + vq.size()) > 0; k++) tick;
        check("queues_drained", 32'(aq.size() + cq.size() + vq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
